// File: rtl/lap_stopwatch.sv
// rtl/lap_stopwatch.sv - single-clock MM:SS[.f] stopwatch, lap capture and 7-seg scan; lap feature under LAP_STOPWATCH_LAP_EN
module lap_stopwatch #(
    parameter  int CLK_DIV     = 1_000_000,
    parameter  int FRAC_DIGITS = 2,
    parameter  int SCAN_DIV    = 100_000,
    localparam int ND          = 4 + FRAC_DIGITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_stop,
    input  logic          clear_btn,
    input  logic          lap_btn,
    output logic [6:0]    seg,
    output logic [ND-1:0] an,
    output logic          running,
    output logic          lap_hold,
    output logic          overflow
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(ND);
    localparam int CW = 4 * ND;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_t;

`ifdef LAP_STOPWATCH_LAP_EN
    localparam int NB = 3;
    logic [NB-1:0] w_btn;
    assign w_btn = {lap_btn, clear_btn, start_stop};
`else
    localparam int NB = 2;
    logic [NB-1:0] w_btn;
    logic          w_lap_unused;
    assign w_btn        = {clear_btn, start_stop};
    assign w_lap_unused = lap_btn;
`endif

    logic [NB-1:0] r_sync1, r_sync2, r_sync2_d, r_pulse;
    state_t        r_state;
    logic          r_running, r_overflow, r_on;
    logic [PW-1:0] r_presc;
    logic [CW-1:0] r_cnt, w_cnt_inc, w_disp;
    logic          w_wrap, w_tick, w_clr, w_start, w_lap_hold, w_slot_end, w_on_nxt;
    logic [SW-1:0] r_scan_cnt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [ND-1:0] r_an;
    logic [6:0]    r_seg;

    function automatic logic [3:0] digit_max(input int pos);
        return (pos == FRAC_DIGITS + 1 || pos == FRAC_DIGITS + 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Two-flop synchronizers followed by a registered rising-edge pulse per button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync2_d <= '0;
            r_pulse   <= '0;
        end else begin
            r_sync1   <= w_btn;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_pulse   <= r_sync2 & ~r_sync2_d;
        end
    end

    // Clear outranks start, start outranks lap
    assign w_clr   = r_pulse[1];
    assign w_start = r_pulse[0] & ~r_pulse[1];
    assign w_tick  = (r_state == S_RUN) && (r_presc == PW'(CLK_DIV - 1));

    // Run-state FSM with registered running decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else if (w_clr) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else if (w_start) begin
            case (r_state)
                S_IDLE:  begin r_state <= S_RUN;   r_running <= 1'b1; end
                S_RUN:   begin r_state <= S_PAUSE; r_running <= 1'b0; end
                S_PAUSE: begin r_state <= S_RUN;   r_running <= 1'b1; end
                default: begin r_state <= S_IDLE;  r_running <= 1'b0; end
            endcase
        end
    end

    // Ripple-carry BCD increment across all digits in one cycle
    always_comb begin
        logic c;
        c         = 1'b1;
        w_cnt_inc = r_cnt;
        for (int i = 0; i < ND; i++) begin
            if (c) begin
                if (r_cnt[4*i +: 4] == digit_max(i)) begin
                    w_cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        w_wrap = c;
    end

    // Prescaler, count and sticky overflow; prescaler holds its phase outside RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if (w_clr) begin
            r_presc    <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                r_presc <= '0;
                r_cnt   <= w_cnt_inc;
                if (w_wrap) r_overflow <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

`ifdef LAP_STOPWATCH_LAP_EN
    logic [CW-1:0] r_lap;
    logic          r_lap_hold, w_lap;
    assign w_lap = r_pulse[2] & ~r_pulse[1] & ~r_pulse[0] & (r_state != S_IDLE);

    // Lap toggles between capture and release; a coincident tick leaves the pre-increment value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap      <= '0;
            r_lap_hold <= 1'b0;
        end else if (w_clr) begin
            r_lap      <= '0;
            r_lap_hold <= 1'b0;
        end else if (w_lap) begin
            if (!r_lap_hold) begin
                r_lap      <= r_cnt;
                r_lap_hold <= 1'b1;
            end else begin
                r_lap_hold <= 1'b0;
            end
        end
    end

    assign w_lap_hold = r_lap_hold;
    assign w_disp     = r_lap_hold ? r_lap : r_cnt;
`else
    assign w_lap_hold = 1'b0;
    assign w_disp     = r_cnt;
`endif

    // Next scan slot; the display stays dark until the first slot completes after reset
    assign w_slot_end = (r_scan_cnt == SW'(SCAN_DIV - 1));
    always_comb begin
        w_on_nxt  = r_on;
        w_idx_nxt = r_idx;
        if (w_slot_end) begin
            w_on_nxt = 1'b1;
            if (r_on) w_idx_nxt = (r_idx == IW'(ND - 1)) ? '0 : r_idx + IW'(1);
        end
    end

    // Anode and segment registers load together from the same index every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_on       <= 1'b0;
            r_an       <= '1;
            r_seg      <= 7'h7F;
        end else begin
            r_scan_cnt <= w_slot_end ? '0 : r_scan_cnt + SW'(1);
            r_idx      <= w_idx_nxt;
            r_on       <= w_on_nxt;
            r_an       <= w_on_nxt ? ~(ND'(1) << w_idx_nxt) : '1;
            r_seg      <= w_on_nxt ? seg7(w_disp[{w_idx_nxt, 2'b00} +: 4]) : 7'h7F;
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign running  = r_running;
    assign lap_hold = w_lap_hold;
    assign overflow = r_overflow;
endmodule
